// File: rtl/report_tx_arbiter.sv
// Round-robin arbiter between two report sources. It forwards the granted frame beat by beat.
// Malformed, stalled or oversize frames are closed with a synthetic discard tail.
module report_tx_arbiter #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_BEATS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req0,
  output logic         o_ack0,
  input  logic [133:0] iv_data0,
  input  logic         i_req1,
  output logic         o_ack1,
  input  logic [133:0] iv_data1,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic         o_data_valid,
  output logic         o_data_valid_wr,
  output logic [15:0]  ov_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_HEAD,
    S_XFER,
    S_ABORT
  } state_t;

  localparam logic [1:0]   TAG_NONE    = 2'b00;
  localparam logic [1:0]   TAG_HEAD    = 2'b01;
  localparam logic [1:0]   TAG_TAIL    = 2'b10;
  localparam logic [6:0]   TIMEOUT_C   = 7'(TIMEOUT);
  localparam logic [7:0]   MAX_BEATS_C = 8'(MAX_BEATS);
  localparam logic [133:0] ABORT_TAIL  = {2'b10, 4'hF, 128'h0};

  state_t         state_q, state_d;
  logic           port_q, port_d;
  logic           rr_q, rr_d;
  logic [6:0]     idle_cnt_q, idle_cnt_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [133:0]   data_q, data_d;
  logic           wr_q, wr_d;
  logic           valid_q, valid_d;
  logic           valid_wr_q, valid_wr_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;

  logic [133:0]   beat_in;
  logic [1:0]     tag;
  logic [6:0]     idle_inc;
  logic           abort;
  logic           pick;

  assign beat_in  = port_q ? iv_data1 : iv_data0;
  assign tag      = beat_in[133:132];
  assign idle_inc = idle_cnt_q + 7'd1;

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    rr_d       = rr_q;
    idle_cnt_d = idle_cnt_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    valid_d    = 1'b0;
    valid_wr_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
    abort      = 1'b0;
    pick       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          // rr_q names the port that wins a tie: the one not granted last time
          pick       = (i_req0 && i_req1) ? rr_q : i_req1;
          port_d     = pick;
          rr_d       = ~pick;
          idle_cnt_d = '0;
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: state_d = S_WAIT_HEAD;
      S_WAIT_HEAD: begin
        case (tag)
          TAG_HEAD: begin
            data_d     = beat_in;
            wr_d       = 1'b1;
            beat_cnt_d = 8'd1;
            idle_cnt_d = '0;
            state_d    = S_XFER;
          end
          TAG_NONE: begin
            idle_cnt_d = idle_inc;
            abort      = (idle_inc == TIMEOUT_C);
          end
          default: abort = 1'b1;
        endcase
      end
      S_XFER: begin
        if (tag == TAG_NONE) begin
          idle_cnt_d = idle_inc;
          abort      = (idle_inc == TIMEOUT_C);
        end else if (tag == TAG_HEAD || beat_cnt_q == MAX_BEATS_C) begin
          abort = 1'b1;
        end else begin
          data_d     = beat_in;
          wr_d       = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          idle_cnt_d = '0;
          if (tag == TAG_TAIL) begin
            valid_d    = 1'b1;
            valid_wr_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The synthetic tail is registered on entry so it is on the outputs during ABORT
    if (abort) begin
      state_d    = S_ABORT;
      data_d     = ABORT_TAIL;
      wr_d       = 1'b1;
      valid_d    = 1'b0;
      valid_wr_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      port_q     <= 1'b0;
      rr_q       <= 1'b0;
      idle_cnt_q <= '0;
      beat_cnt_q <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      rr_q       <= rr_d;
      idle_cnt_q <= idle_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_ack0          = (state_q == S_GRANT) && !port_q;
  assign o_ack1          = (state_q == S_GRANT) && port_q;
  assign ov_data         = data_q;
  assign o_data_wr       = wr_q;
  assign o_data_valid    = valid_q;
  assign o_data_valid_wr = valid_wr_q;
  assign ov_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_report_tx_arbiter.sv
// Directed bench for report_tx_arbiter: per-port frame drivers push expected beats into a
// scoreboard, and an output monitor pops and compares every written beat.
module tb_report_tx_arbiter;

  typedef logic [133:0] beat_t;
  typedef beat_t beat_q_t[$];
  typedef struct packed {
    beat_t d;
    logic  vwr;
    logic  v;
  } exp_t;

  localparam beat_t ABORT_TAIL = {2'b10, 4'hF, 128'h0};

  logic        clk;
  logic        rst_n;
  logic        i_req0, i_req1;
  logic        o_ack0, o_ack1;
  beat_t       iv_data0, iv_data1;
  beat_t       ov_data;
  logic        o_data_wr, o_data_valid, o_data_valid_wr;
  logic [15:0] ov_drop_cnt;

  int      checks = 0;
  int      errors = 0;
  exp_t    sb[$];
  beat_q_t empty_q;

  report_tx_arbiter #(.TIMEOUT(64), .MAX_BEATS(128)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req0         (i_req0),
    .o_ack0         (o_ack0),
    .iv_data0       (iv_data0),
    .i_req1         (i_req1),
    .o_ack1         (o_ack1),
    .iv_data1       (iv_data1),
    .ov_data        (ov_data),
    .o_data_wr      (o_data_wr),
    .o_data_valid   (o_data_valid),
    .o_data_valid_wr(o_data_valid_wr),
    .ov_drop_cnt    (ov_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] tag, input int p, input int i);
    logic [3:0] ib;
    ib = i[3:0];
    return {tag, ib, p[31:0], i[31:0], 32'hCAFE_F00D, ~i[31:0]};
  endfunction

  function automatic beat_q_t mk_frame(input int p, input int nbody, input bit tail);
    beat_q_t q;
    q.push_back(mk(2'b01, p, 0));
    for (int i = 1; i <= nbody; i++) q.push_back(mk(2'b11, p, i));
    if (tail) q.push_back(mk(2'b10, p, nbody + 1));
    return q;
  endfunction

  task automatic set_req(input int p, input logic v);
    if (p == 0) i_req0 = v;
    else        i_req1 = v;
  endtask

  task automatic set_data(input int p, input beat_t v);
    if (p == 0) iv_data0 = v;
    else        iv_data1 = v;
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? o_ack0 : o_ack1;
  endfunction

  // Requests port p, waits for its grant, then sends the beats one per cycle.
  // The first n_fwd beats must come out one cycle later; abort_exp adds a discard tail.
  task automatic run_port(input int p, input beat_q_t beats, input int n_fwd,
                          input bit abort_exp, input int exp_wait);
    int  w;
    bit  got;
    exp_t e;
    set_req(p, 1'b1);
    set_data(p, '0);
    got = 1'b0;
    for (w = 1; w <= 1000; w++) begin
      @(negedge clk);
      if (ack_of(p)) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("ack_seen_p%0d", p), got, 1);
    if (!got) begin
      set_req(p, 1'b0);
      return;
    end
    if (exp_wait >= 0) chk($sformatf("ack_latency_p%0d", p), w, exp_wait);
    for (int i = 0; i < n_fwd; i++) begin
      e.d   = beats[i];
      e.vwr = (beats[i][133:132] == 2'b10);
      e.v   = e.vwr;
      sb.push_back(e);
    end
    if (abort_exp) begin
      e.d = ABORT_TAIL; e.vwr = 1'b1; e.v = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    chk($sformatf("ack_pulse_width_p%0d", p), ack_of(p), 0);
    foreach (beats[i]) begin
      set_data(p, beats[i]);
      @(negedge clk);
      if (i < n_fwd) begin
        chk($sformatf("latency_wr_p%0d_b%0d", p, i), o_data_wr, 1);
        chk($sformatf("latency_data_p%0d_b%0d", p, i), ov_data, beats[i]);
      end
    end
    set_data(p, '0);
    got = 1'b0;
    for (w = 0; w < 200; w++) begin
      if (o_data_valid_wr) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("frame_end_seen_p%0d", p), got, 1);
    set_req(p, 1'b0);
  endtask

  // Output monitor and scoreboard checker
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (o_ack0 && o_ack1) begin
          checks++; errors++;
          $display("FAIL dual_ack: both acks high");
        end
        if (o_data_wr === 1'b1) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", ov_data);
          end else begin
            e = sb.pop_front();
            chk("sb_data", ov_data, e.d);
            chk("sb_verdict", {o_data_valid_wr, o_data_valid}, {e.vwr, e.v});
            if (o_data_valid_wr)
              $display("frame end: valid=%0b tag_data=%h drop_cnt=%0d",
                       o_data_valid, ov_data, ov_drop_cnt);
          end
        end else if (o_data_valid_wr === 1'b1) begin
          checks++; errors++;
          $display("FAIL stray_verdict: valid_wr=1 with data_wr=0");
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_q_t f;
    rst_n = 1'b0;
    i_req0 = 1'b0; i_req1 = 1'b0;
    iv_data0 = '0; iv_data1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", ov_data, 0);
    chk("rst_ctrl", {o_data_wr, o_data_valid, o_data_valid_wr, o_ack0, o_ack1}, 0);
    chk("rst_drop", ov_drop_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous requests from reset: port 0 first, then port 1
    fork
      run_port(0, mk_frame(0, 1, 1), 3, 1'b0, 1);
      run_port(1, mk_frame(1, 2, 1), 4, 1'b0, -1);
    join
    repeat (2) @(negedge clk);
    // Port 1 was granted last, so port 0 wins again
    fork
      run_port(0, mk_frame(0, 3, 1), 5, 1'b0, 1);
      run_port(1, mk_frame(1, 0, 1), 2, 1'b0, -1);
    join
    repeat (2) @(negedge clk);

    // Lone port 0 frame: head, 2 bodies, tail
    run_port(0, mk_frame(0, 2, 1), 4, 1'b0, 1);
    chk("drop_after_good", ov_drop_cnt, 0);
    repeat (2) @(negedge clk);

    // Port 1 granted but never sends a head
    run_port(1, empty_q, 0, 1'b1, 1);
    chk("drop_after_head_timeout", ov_drop_cnt, 1);
    repeat (2) @(negedge clk);

    // Head, body, then silence until the idle timeout
    run_port(0, mk_frame(0, 1, 0), 2, 1'b1, 1);
    chk("drop_after_idle_timeout", ov_drop_cnt, 2);
    repeat (2) @(negedge clk);

    // 129-beat frame: beat 129 is replaced by the discard tail
    run_port(0, mk_frame(0, 127, 1), 128, 1'b1, -1);
    chk("drop_after_oversize", ov_drop_cnt, 3);
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame, right after beat 3 is on the output
    f = mk_frame(0, 4, 1);
    i_req0 = 1'b1;
    @(negedge clk);
    chk("mid_ack", o_ack0, 1);
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.d = f[i]; e.vwr = 1'b0; e.v = 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv_data0 = f[i];
    end
    @(negedge clk);
    chk("mid_beat3", ov_data, f[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", ov_data, 0);
    chk("async_rst_ctrl", {o_data_wr, o_data_valid, o_data_valid_wr, o_ack0, o_ack1}, 0);
    chk("async_rst_drop", ov_drop_cnt, 0);
    i_req0 = 1'b0;
    iv_data0 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_port(0, mk_frame(0, 2, 1), 4, 1'b0, 1);
    chk("drop_after_reset_frame", ov_drop_cnt, 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
